mdu_unit: RTL
=============

# mdu_unit

Parametrised multiply/divide execution unit for the RISC-V core's EX stage, covering the M extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It decodes the same ALUOp/Funct7/Funct3 fields as the base ALU control. Unlike the base ALU path it is multi-cycle: operations use a valid/ready handshake and assert a stall toward the pipeline while iterating. It is generalised in operand width.

## Interface
- XLEN, 32, operand/result width; ≥ 8, power of two
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort of any operation in flight
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- ALUOp  in  2  controller opcode class; 2'b10 = R-type
- Funct7  in  7  instruction bits 31:25
- Funct3  in  3  instruction bits 14:12
- SrcA  in  XLEN  rs1 operand
- SrcB  in  XLEN  rs2 operand
- out_valid  out  1  Result valid
- out_ready  in  1  consumer takes Result
- Result  out  XLEN  operation result
- Illegal  out  1  accepted request was not an M-op; qualified by out_valid
- busy  out  1  pipeline stall request

## Operation
- Decode: M-op iff ALUOp==2'b10 && Funct7==7'b0000001. Funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE) && !flush. busy = (state==MUL || state==DIV). out_valid = (state==DONE).
- Accept on in_valid && in_ready. Capture operands, op and signedness.
  - Non-M request: go to DONE with Result=0, Illegal=1.
  - Divisor zero: go to DONE directly. Quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM, SrcA = most-negative, SrcB = -1): go to DONE directly. Quotient = SrcA; remainder = 0.
  - Other multiplies: go to MUL. Other divides: go to DIV.
- MUL state: shift-add on operand magnitudes, one bit per cycle, XLEN iterations. Accumulator is 2·XLEN bits.
- DIV state: restoring division on magnitudes, one quotient bit per cycle, XLEN iterations.
- Iteration counter: $clog2(XLEN)+1 bits, loaded with XLEN, decremented each iteration. The exit edge is at count 1.
- Sign fix-up is applied on the exit edge:
  - Product is negated if the operand signs differ; signedness is per op, MULHSU treats only SrcA as signed.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Result selection: MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- DONE: Result and Illegal are held stable until out_ready. On out_valid && out_ready, go to IDLE. There is no accept in DONE.

## Timing
- Reset values: state IDLE, out_valid 0, Result 0, Illegal 0, busy 0, in_ready 1 once reset deasserts (in_ready is 0 while reset is high).
- Acceptance cycle = cycle 0.
  - Iterative ops: busy in cycles 1..XLEN; out_valid in cycle XLEN+1.
  - Illegal, divide-by-zero and overflow cases: out_valid in cycle 1.
- Back-to-back issue rate: one op per (latency + 1) cycles, minimum 2.
- flush: returns to IDLE at the next edge from any state and discards Result (out_valid drops).
  - flush together with in_valid: nothing is accepted.
  - Priority is reset > flush > handshake.
- reset mid-operation behaves like flush and also clears Result and Illegal.

## Configuration
- MDU_FAST_MUL_EN defined: the MUL state is unused. All multiplies complete with out_valid in cycle 1, using a single-cycle 2·XLEN signed multiply of sign/zero-extended operands (XLEN+1 bits).
- MDU_FAST_MUL_EN undefined: iterative multiply as described above. Division is always iterative.

## Structure
- Package mdu_pkg holds:
  - state enum mdu_state_e
  - op enum mdu_op_e (8 values, Funct3 encoding)
  - localparams ALUOP_RTYPE = 2'b10 and FUNCT7_MULDIV = 7'b0000001
  - a decode function returning op, signedA, signedB and isM
- Sub-module mdu_div_core: restoring divider datapath with start/iterate/done signals and a quotient/remainder output. The top level owns the FSM, the multiplier and sign fix-up.

## Test plan
- MUL 7 × -3 (XLEN=32) → Result 0xFFFFFFEB. out_valid at cycle 33 without the macro, cycle 1 with it.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD. REM -7 % 2 → 0xFFFFFFFF. Both give out_valid at cycle 33.
- DIVU 9 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5, both at cycle 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, both at cycle 1.
- flush in cycle 10 of a DIV → out_valid never asserts, in_ready = 1 in cycle 11, the next request completes correctly.
- out_ready held low 3 cycles in DONE → Result stable, in_ready = 0. A request with ALUOp=00 → Illegal = 1, Result = 0, out_valid at cycle 1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types, constants and instruction decode for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        mdu_op_e op;
        logic    signed_a;
        logic    signed_b;
        logic    is_m;
    } mdu_dec_t;

    // MUL low half is sign-agnostic; treating it as signed keeps the fix-up uniform.
    function automatic mdu_dec_t mdu_decode(input logic [1:0] aluop,
                                            input logic [6:0] funct7,
                                            input logic [2:0] funct3);
        mdu_dec_t d;
        d.op       = mdu_op_e'(funct3);
        d.is_m     = (aluop == ALUOP_RTYPE) && (funct7 == FUNCT7_MULDIV);
        d.signed_a = (d.op == OP_MUL) || (d.op == OP_MULH) || (d.op == OP_MULHSU) ||
                     (d.op == OP_DIV) || (d.op == OP_REM);
        d.signed_b = (d.op == OP_MUL) || (d.op == OP_MULH) ||
                     (d.op == OP_DIV) || (d.op == OP_REM);
        return d;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per iterate pulse.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            iterate,
    input  logic            last,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done_c,
    output logic [XLEN-1:0] quotient_c,
    output logic [XLEN-1:0] remainder_c
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   trial;
    logic            ge;

    // Shift next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        trial       = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        ge          = !trial[XLEN];
        remainder_c = ge ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quotient_c  = {quo_q[XLEN-2:0], ge};
        done_c      = iterate && last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (iterate) begin
            rem_q <= remainder_c;
            quo_q <= quotient_c;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle RISC-V M-extension unit: FSM, shift-add multiplier, sign fix-up.
// Define MDU_FAST_MUL_EN to complete all multiplies in one cycle.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            Illegal,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state, state_next;
    mdu_dec_t          dec;
    logic              accept, is_div, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [CW-1:0]     count;
    logic              neg_q, hi_sel, rem_sel;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] acc, acc_next, prod_fix;
    logic [XLEN:0]     mul_sum;
    logic              div_done_c;
    logic [XLEN-1:0]   div_quo_c, div_rem_c, q_fix, r_fix;
`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN-1:0] fast_prod;
`endif

    // Request decode, operand magnitudes and early-exit detection.
    always_comb begin
        dec      = mdu_decode(ALUOp, Funct7, Funct3);
        accept   = in_valid && in_ready;
        is_div   = Funct3[2];
        a_neg    = dec.signed_a && SrcA[XLEN-1];
        b_neg    = dec.signed_b && SrcB[XLEN-1];
        mag_a    = a_neg ? XLEN'(0) - SrcA : SrcA;
        mag_b    = b_neg ? XLEN'(0) - SrcB : SrcB;
        div_zero = (SrcB == '0);
        div_ovf  = dec.signed_a && dec.signed_b && (SrcA == MIN_NEG) && (SrcB == '1);
    end

`ifdef MDU_FAST_MUL_EN
    always_comb begin
        fast_a    = {dec.signed_a & SrcA[XLEN-1], SrcA};
        fast_b    = {dec.signed_b & SrcB[XLEN-1], SrcB};
        fast_prod = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
    end
`endif

    // One shift-add step: multiplier sits in the low half of acc and shifts out.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {mul_sum, acc[XLEN-1:1]};
        prod_fix = neg_q ? (2*XLEN)'(0) - acc_next : acc_next;
        q_fix    = neg_q ? XLEN'(0) - div_quo_c : div_quo_c;
        r_fix    = neg_q ? XLEN'(0) - div_rem_c : div_rem_c;
    end

    mdu_div_core #(.XLEN(XLEN)) u_div (
        .clk         (clk),
        .reset       (reset),
        .start       (accept && is_div),
        .iterate     ((state == S_DIV) && !flush),
        .last        (count == CW'(1)),
        .dividend    (mag_a),
        .divisor     (mag_b),
        .done_c      (div_done_c),
        .quotient_c  (div_quo_c),
        .remainder_c (div_rem_c)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) begin
                if (!dec.is_m)                    state_next = S_DONE;
                else if (is_div)                  state_next = (div_zero || div_ovf) ? S_DONE : S_DIV;
                else begin
`ifdef MDU_FAST_MUL_EN
                                                  state_next = S_DONE;
`else
                                                  state_next = S_MUL;
`endif
                end
            end
            S_MUL:  if (count == CW'(1)) state_next = S_DONE;
            S_DIV:  if (div_done_c)      state_next = S_DONE;
            S_DONE: if (out_ready)       state_next = S_IDLE;
            default:                     state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    always_comb begin
        in_ready  = (state == S_IDLE) && !flush && !reset;
        busy      = (state == S_MUL) || (state == S_DIV);
        out_valid = (state == S_DONE);
    end

    // Datapath: capture on accept, iterate, and write the fixed-up result on exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            Result  <= '0;
            Illegal <= 1'b0;
            count   <= '0;
            neg_q   <= 1'b0;
            hi_sel  <= 1'b0;
            rem_sel <= 1'b0;
            mcand   <= '0;
            acc     <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: if (accept) begin
                    Illegal <= !dec.is_m;
                    count   <= CW'(XLEN);
                    neg_q   <= (is_div && Funct3[1]) ? a_neg : (a_neg ^ b_neg);
                    hi_sel  <= (Funct3 != 3'b000);
                    rem_sel <= Funct3[1];
                    mcand   <= mag_a;
                    acc     <= {{XLEN{1'b0}}, mag_b};
                    if (!dec.is_m)              Result <= '0;
                    else if (is_div && div_zero) Result <= Funct3[1] ? SrcA : '1;
                    else if (is_div && div_ovf)  Result <= Funct3[1] ? '0 : SrcA;
`ifdef MDU_FAST_MUL_EN
                    else if (!is_div)
                        Result <= (Funct3 != 3'b000) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
`endif
                end
                S_MUL: begin
                    acc   <= acc_next;
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        Result <= hi_sel ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
                end
                S_DIV: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) Result <= rem_sel ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end

endmodule
